sdr_arbiter: RTL and testbench

Two-port request scheduler in front of `sdr_as_ram`. It shares the single SDRAM command interface between two requesters: port 0 is the CPU data bus and port 1 is the instruction fetch/DMA bus. It serialises their read and write commands with round-robin fairness and inserts periodic auto-refresh requests. It routes returned read data back to the issuing port.

---
 rtl/sdr_arb_pkg.sv | 30 +++
 rtl/sdr_rr_arb2.sv | 40 ++++
 rtl/sdr_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_sdr_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdr_arb_pkg : shared types and widths for the two-port SDRAM arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package sdr_arb_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;
  localparam int DM_W   = 4;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_CMD     = 3'd2,
    S_WAIT_WR = 3'd3,
    S_WAIT_RD = 3'd4
  } arb_state_t;

  typedef logic port_id_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DM_W-1:0]   dm;
    logic [DATA_W-1:0] wdata;
  } port_req_t;

endpackage
`default_nettype wire

// File: rtl/sdr_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdr_rr_arb2 : combinational 2-way round-robin grant with registered last winner
// Rev 1.0
// ----------------------------------------------------------------------------
module sdr_rr_arb2
  import sdr_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_req0,
  input  logic     i_req1,
  input  logic     i_update,
  output logic     o_gnt_valid,
  output port_id_t o_gnt_id
);

  port_id_t r_last;

  // On a tie the port that did not win last time takes the grant.
  always_comb begin
    o_gnt_valid = i_req0 | i_req1;
    o_gnt_id    = 1'b0;
    if (i_req0 && i_req1) begin
      o_gnt_id = ~r_last;
    end else if (i_req1) begin
      o_gnt_id = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (i_update && o_gnt_valid) begin
      r_last <= o_gnt_id;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdr_arbiter : serialises two requesters plus periodic refresh onto sdr_as_ram
// Rev 1.0
// ----------------------------------------------------------------------------
module sdr_arbiter
  import sdr_arb_pkg::*;
#(
  parameter int REF_CYCLES = 780,
  parameter int CMD_GUARD  = 2,
  parameter int RD_TIMEOUT = 64
) (
  input  logic              Sdr_clk,
  input  logic              Rst,
  input  logic              P0_req,
  input  logic              P0_we,
  input  logic [ADDR_W-1:0] P0_addr,
  input  logic [DM_W-1:0]   P0_dm,
  input  logic [DATA_W-1:0] P0_wdata,
  output logic              P0_ack,
  output logic              P0_rvalid,
  output logic [DATA_W-1:0] P0_rdata,
  input  logic              P1_req,
  input  logic              P1_we,
  input  logic [ADDR_W-1:0] P1_addr,
  input  logic [DM_W-1:0]   P1_dm,
  input  logic [DATA_W-1:0] P1_wdata,
  output logic              P1_ack,
  output logic              P1_rvalid,
  output logic [DATA_W-1:0] P1_rdata,
  input  logic              Sdr_init_done,
  input  logic              Sdr_busy,
  input  logic              Sdr_rd_en,
  input  logic [DATA_W-1:0] Sdr_rd_dout,
  output logic              App_wr_en,
  output logic              App_rd_en,
  output logic              App_ref_req,
  output logic [ADDR_W-1:0] App_wr_addr,
  output logic [ADDR_W-1:0] App_rd_addr,
  output logic [DM_W-1:0]   App_wr_dm,
  output logic [DATA_W-1:0] App_wr_din,
  output logic              Rd_timeout_err
);

  localparam int REF_W   = (REF_CYCLES > 1) ? $clog2(REF_CYCLES) : 1;
  localparam int GUARD_W = (CMD_GUARD > 1)  ? $clog2(CMD_GUARD)  : 1;
  localparam int TMO_W   = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  arb_state_t        r_state;
  logic [REF_W-1:0]  r_ref_cnt;
  logic              r_ref_pend;
  logic [GUARD_W-1:0] r_guard;
  logic [TMO_W-1:0]  r_tmo;
  port_id_t          r_owner;

  logic              r_p0_ack, r_p1_ack, r_p0_rvalid, r_p1_rvalid;
  logic [DATA_W-1:0] r_p0_rdata, r_p1_rdata;
  logic              r_wr_en, r_rd_en, r_ref_req, r_tmo_err;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic [DM_W-1:0]   r_wr_dm;
  logic [DATA_W-1:0] r_wr_din;

  logic              w_gnt_valid;
  port_id_t          w_gnt_id;
  logic              w_port_slot;
  logic              w_ref_wrap;
  port_req_t         w_sel;

  // A port may only win an IDLE cycle that refresh has not claimed.
  assign w_port_slot = (r_state == S_IDLE) && !r_ref_pend;
  assign w_ref_wrap  = (r_state != S_INIT) && (r_ref_cnt == REF_W'(REF_CYCLES - 1));

  sdr_rr_arb2 u_rr (
    .clk         (Sdr_clk),
    .rst         (Rst),
    .i_req0      (P0_req),
    .i_req1      (P1_req),
    .i_update    (w_port_slot),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  always_comb begin
    w_sel = '{we: P0_we, addr: P0_addr, dm: P0_dm, wdata: P0_wdata};
    if (w_gnt_id) begin
      w_sel = '{we: P1_we, addr: P1_addr, dm: P1_dm, wdata: P1_wdata};
    end
  end

  // A wrap coinciding with a refresh issue keeps the new request pending.
  always_ff @(posedge Sdr_clk) begin
    if (Rst) begin
      r_ref_cnt  <= '0;
      r_ref_pend <= 1'b0;
    end else begin
      if (r_state == S_INIT || w_ref_wrap) begin
        r_ref_cnt <= '0;
      end else begin
        r_ref_cnt <= r_ref_cnt + 1'b1;
      end
      if (w_ref_wrap) begin
        r_ref_pend <= 1'b1;
      end else if (r_state == S_IDLE && r_ref_pend) begin
        r_ref_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge Sdr_clk) begin
    if (Rst) begin
      r_state     <= S_INIT;
      r_guard     <= '0;
      r_tmo       <= '0;
      r_owner     <= 1'b0;
      r_p0_ack    <= 1'b0;
      r_p1_ack    <= 1'b0;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_ref_req   <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_wr_dm     <= '0;
      r_wr_din    <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_p0_ack    <= 1'b0;
      r_p1_ack    <= 1'b0;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_ref_req   <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (Sdr_init_done) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (r_ref_pend) begin
            r_ref_req <= 1'b1;
            r_state   <= S_CMD;
          end else if (w_gnt_valid) begin
            r_owner  <= w_gnt_id;
            r_p0_ack <= ~w_gnt_id;
            r_p1_ack <= w_gnt_id;
            if (w_sel.we) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= w_sel.addr;
              r_wr_dm   <= w_sel.dm;
              r_wr_din  <= w_sel.wdata;
            end else begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_sel.addr;
            end
            r_state <= S_CMD;
          end
        end
        S_CMD: begin
          r_guard <= '0;
          r_tmo   <= '0;
          r_state <= r_rd_en ? S_WAIT_RD : S_WAIT_WR;
        end
        S_WAIT_WR: begin
          if (r_guard == GUARD_W'(CMD_GUARD - 1)) begin
            if (!Sdr_busy) r_state <= S_IDLE;
          end else begin
            r_guard <= r_guard + 1'b1;
          end
        end
        S_WAIT_RD: begin
          if (Sdr_rd_en || r_tmo == TMO_W'(RD_TIMEOUT - 1)) begin
            // An aborted read still completes to its owner, with zero data.
            if (r_owner) begin
              r_p1_rvalid <= 1'b1;
              r_p1_rdata  <= Sdr_rd_en ? Sdr_rd_dout : '0;
            end else begin
              r_p0_rvalid <= 1'b1;
              r_p0_rdata  <= Sdr_rd_en ? Sdr_rd_dout : '0;
            end
            if (!Sdr_rd_en) r_tmo_err <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign P0_ack         = r_p0_ack;
  assign P1_ack         = r_p1_ack;
  assign P0_rvalid      = r_p0_rvalid;
  assign P1_rvalid      = r_p1_rvalid;
  assign P0_rdata       = r_p0_rdata;
  assign P1_rdata       = r_p1_rdata;
  assign App_wr_en      = r_wr_en;
  assign App_rd_en      = r_rd_en;
  assign App_ref_req    = r_ref_req;
  assign App_wr_addr    = r_wr_addr;
  assign App_rd_addr    = r_rd_addr;
  assign App_wr_dm      = r_wr_dm;
  assign App_wr_din     = r_wr_din;
  assign Rd_timeout_err = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_sdr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sdr_arbiter : directed bench with an sdr_as_ram model and read scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdr_arbiter;

  localparam int REF_CYCLES = 16;
  localparam int CMD_GUARD  = 2;
  localparam int RD_TIMEOUT = 64;
  localparam int RD_LAT     = 5;

  logic        Sdr_clk = 1'b0;
  logic        Rst = 1'b1;
  logic        P0_req = 1'b0, P0_we = 1'b0, P1_req = 1'b0, P1_we = 1'b0;
  logic [20:0] P0_addr = '0, P1_addr = '0;
  logic [3:0]  P0_dm = '0, P1_dm = '0;
  logic [31:0] P0_wdata = '0, P1_wdata = '0;
  logic        Sdr_init_done = 1'b0, Sdr_busy = 1'b0, Sdr_rd_en = 1'b0;
  logic [31:0] Sdr_rd_dout = '0;
  logic        P0_ack, P1_ack, P0_rvalid, P1_rvalid;
  logic [31:0] P0_rdata, P1_rdata;
  logic        App_wr_en, App_rd_en, App_ref_req, Rd_timeout_err;
  logic [20:0] App_wr_addr, App_rd_addr;
  logic [3:0]  App_wr_dm;
  logic [31:0] App_wr_din;
  logic [149:0] all_out;

  always #5 Sdr_clk = ~Sdr_clk;

  sdr_arbiter #(.REF_CYCLES(REF_CYCLES), .CMD_GUARD(CMD_GUARD), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .Sdr_clk(Sdr_clk), .Rst(Rst),
    .P0_req(P0_req), .P0_we(P0_we), .P0_addr(P0_addr), .P0_dm(P0_dm), .P0_wdata(P0_wdata),
    .P0_ack(P0_ack), .P0_rvalid(P0_rvalid), .P0_rdata(P0_rdata),
    .P1_req(P1_req), .P1_we(P1_we), .P1_addr(P1_addr), .P1_dm(P1_dm), .P1_wdata(P1_wdata),
    .P1_ack(P1_ack), .P1_rvalid(P1_rvalid), .P1_rdata(P1_rdata),
    .Sdr_init_done(Sdr_init_done), .Sdr_busy(Sdr_busy),
    .Sdr_rd_en(Sdr_rd_en), .Sdr_rd_dout(Sdr_rd_dout),
    .App_wr_en(App_wr_en), .App_rd_en(App_rd_en), .App_ref_req(App_ref_req),
    .App_wr_addr(App_wr_addr), .App_rd_addr(App_rd_addr),
    .App_wr_dm(App_wr_dm), .App_wr_din(App_wr_din), .Rd_timeout_err(Rd_timeout_err)
  );

  assign all_out = {P0_ack, P1_ack, P0_rvalid, P1_rvalid, P0_rdata, P1_rdata,
                    App_wr_en, App_rd_en, App_ref_req, App_wr_addr, App_rd_addr,
                    App_wr_dm, App_wr_din, Rd_timeout_err};

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [31:0] q_exp0[$];
  logic [31:0] q_exp1[$];
  logic        mdl_on = 1'b1;
  int          busy_len = 0;
  int          busy_cnt = 0;
  int          rd_cnt = 0;
  logic [20:0] rd_addr = '0;

  // Model memory contents: odd addresses carry an A5A5 tag, even ones 5A5A.
  function automatic logic [31:0] rdval(input logic [20:0] a);
    return (a[0] ? 32'hA5A5_0000 : 32'h5A5A_0000) | {11'h0, a};
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Monitor, scoreboard and sdr_as_ram model, all on the falling edge.
  always @(negedge Sdr_clk) begin
    cyc++;
    if (App_wr_en | App_rd_en | App_ref_req | P0_ack | P1_ack)
      check("cmd_onehot",
            160'({$countones({App_wr_en, App_rd_en, App_ref_req}) == 1, P0_ack & P1_ack,
                  App_ref_req & (P0_ack | P1_ack)}), 160'(3'b100));
    if (P0_ack) begin
      if (P0_we) check("p0_wr_cmd", 160'({App_wr_en, App_rd_en, App_wr_addr, App_wr_dm, App_wr_din}),
                       160'({2'b10, P0_addr, P0_dm, P0_wdata}));
      else begin
        check("p0_rd_cmd", 160'({App_wr_en, App_rd_en, App_rd_addr}), 160'({2'b01, P0_addr}));
        q_exp0.push_back(mdl_on ? rdval(P0_addr) : 32'h0);
      end
    end
    if (P1_ack) begin
      if (P1_we) check("p1_wr_cmd", 160'({App_wr_en, App_rd_en, App_wr_addr, App_wr_dm, App_wr_din}),
                       160'({2'b10, P1_addr, P1_dm, P1_wdata}));
      else begin
        check("p1_rd_cmd", 160'({App_wr_en, App_rd_en, App_rd_addr}), 160'({2'b01, P1_addr}));
        q_exp1.push_back(mdl_on ? rdval(P1_addr) : 32'h0);
      end
    end
    if (P0_rvalid) begin
      if (q_exp0.size() == 0) check("p0_rvalid_unexpected", 160'(P0_rvalid), 160'(0));
      else check("p0_rdata", 160'(P0_rdata), 160'(q_exp0.pop_front()));
    end
    if (P1_rvalid) begin
      if (q_exp1.size() == 0) check("p1_rvalid_unexpected", 160'(P1_rvalid), 160'(0));
      else check("p1_rdata", 160'(P1_rdata), 160'(q_exp1.pop_front()));
    end
    Sdr_rd_en = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        Sdr_rd_en   = 1'b1;
        Sdr_rd_dout = rdval(rd_addr);
      end
    end
    if (App_rd_en && mdl_on) begin
      rd_cnt  = RD_LAT;
      rd_addr = App_rd_addr;
    end
    if (busy_cnt > 0) busy_cnt--;
    if (App_wr_en | App_ref_req) busy_cnt = busy_len;
    Sdr_busy = (busy_cnt > 0);
  end

  task automatic step();
    @(posedge Sdr_clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic we, input logic [20:0] a,
                         input logic [3:0] dm, input logic [31:0] wd);
    if (p == 0) begin
      P0_we = we; P0_addr = a; P0_dm = dm; P0_wdata = wd; P0_req = 1'b1;
    end else begin
      P1_we = we; P1_addr = a; P1_dm = dm; P1_wdata = wd; P1_req = 1'b1;
    end
  endtask

  // Returns the cycle of the CMD carrying the ack; request drops after CMD.
  task automatic wait_ack(input int p, output int c);
    c = -1;
    for (int i = 0; i < 400; i++) begin
      if ((p == 0 && P0_ack) || (p == 1 && P1_ack)) begin
        c = cyc;
        break;
      end
      step();
    end
    check("ack_seen", 160'(c >= 0), 160'(1));
    step();
    if (p == 0) P0_req = 1'b0;
    else P1_req = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (q_exp0.size() == 0 && q_exp1.size() == 0) break;
      step();
    end
    repeat (8) step();
    check("drain", 160'(q_exp0.size() + q_exp1.size()), 160'(0));
  endtask

  task automatic next_cmd(output int c);
    c = -1000;
    for (int i = 0; i < 60; i++) begin
      if (App_wr_en | App_rd_en | App_ref_req) begin
        c = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic wait_ref(output int c);
    c = -1000;
    for (int i = 0; i < 40; i++) begin
      step();
      if (App_ref_req) begin
        c = cyc;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0, c1, c2, c3, got;
    int acks[$];

    // Reset state and INIT hold-off.
    repeat (3) step();
    check("reset_outputs", 160'(all_out), 160'(0));
    Rst = 1'b0;
    set_req(0, 1'b1, 21'h01234, 4'b0011, 32'hDEAD_BEEF);
    got = 0;
    repeat (100) begin
      step();
      if (P0_ack) got++;
    end
    check("init_no_ack", 160'(got), 160'(0));
    Sdr_init_done = 1'b1;
    c0 = cyc;
    wait_ack(0, c1);
    check("first_ack_latency", 160'(c1 - c0), 160'(2));
    wait_drain();

    // Minimum command spacing with Sdr_busy low.
    set_req(0, 1'b1, 21'h00100, 4'b1111, 32'hCAFE_0001);
    wait_ack(0, c0);
    set_req(1, 1'b1, 21'h00200, 4'b1000, 32'hCAFE_0002);
    next_cmd(c1);
    check("cmd_spacing_min", 160'(c1 - c0), 160'(4));
    wait_ack(1, c2);
    wait_drain();

    // Masked write, next grant held off by Sdr_busy.
    busy_len = 8;
    set_req(1, 1'b1, 21'h1ABCD, 4'b0101, 32'h1234_5678);
    wait_ack(1, c0);
    set_req(0, 1'b0, 21'h00005, 4'h0, 32'h0);
    next_cmd(c1);
    check("cmd_spacing_busy", 160'(c1 - c0), 160'(10));
    wait_ack(0, c2);
    busy_len = 0;
    wait_drain();

    // Refresh cadence on an idle bus.
    wait_ref(c0);
    wait_ref(c1);
    wait_ref(c2);
    wait_ref(c3);
    check("ref_period_a", 160'(c2 - c1), 160'(REF_CYCLES));
    check("ref_period_b", 160'(c3 - c2), 160'(REF_CYCLES));

    // Read abort when the memory never answers.
    mdl_on = 1'b0;
    set_req(0, 1'b0, 21'h00003, 4'h0, 32'h0);
    wait_ack(0, c0);
    got = -1000;
    for (int i = 0; i < 100; i++) begin
      step();
      if (P0_rvalid) begin
        got = cyc;
        break;
      end
    end
    check("timeout_latency", 160'(got - c0), 160'(RD_TIMEOUT + 1));
    check("timeout_err", 160'(Rd_timeout_err), 160'(1));
    mdl_on = 1'b1;
    repeat (5) step();
    check("timeout_err_sticky", 160'(Rd_timeout_err), 160'(1));
    wait_drain();

    // Reset in the middle of a read.
    set_req(1, 1'b0, 21'h00002, 4'h0, 32'h0);
    wait_ack(1, c0);
    step();
    Rst = 1'b1;
    Sdr_init_done = 1'b0;
    step();
    check("rst_outputs", 160'(all_out), 160'(0));
    Rst = 1'b0;
    q_exp1.delete();
    set_req(0, 1'b0, 21'h00001, 4'h0, 32'h0);
    got = 0;
    repeat (12) begin
      step();
      if (P0_ack | P1_ack | P0_rvalid | P1_rvalid) got++;
    end
    check("rst_quiet_in_init", 160'(got), 160'(0));

    // Both ports streaming reads: strict alternation starting with port 0.
    set_req(1, 1'b0, 21'h00002, 4'h0, 32'h0);
    Sdr_init_done = 1'b1;
    for (int i = 0; i < 200 && acks.size() < 6; i++) begin
      step();
      if (P0_ack) acks.push_back(0);
      if (P1_ack) acks.push_back(1);
    end
    P0_req = 1'b0;
    P1_req = 1'b0;
    check("alt_count", 160'(acks.size()), 160'(6));
    for (int k = 0; k < acks.size(); k++)
      check("alt_order", 160'(acks[k]), 160'(k % 2));
    wait_drain();
    check("p0_rdata_hold", 160'(P0_rdata), 160'(32'hA5A5_0001));
    check("p1_rdata_hold", 160'(P1_rdata), 160'(32'h5A5A_0002));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
